// File: rtl/sqrt_rr_scheduler_pkg.sv
// Shared types for the square-root scheduler: request bundle and FSM state encoding.
package sqrt_rr_scheduler_pkg;

    localparam int LAMP_FLOAT_F_DW = 7;
    localparam int SIG_W           = LAMP_FLOAT_F_DW + 1;

    typedef struct packed {
        logic [SIG_W-1:0] s;
        logic             exp_odd;
        logic             inv;
        logic             special;
    } sqrt_req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sqrtSchedState_t;

endpackage

// File: rtl/sqrt_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after last_i, wrapping around.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    int cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last_i) + i) % NUM_REQ;
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sqrt_rr_scheduler.sv
// Shares one square-root unit between NUM_REQ requesters with round-robin grants,
// one op in flight, and valid/ready handshakes on both request and response sides.
module sqrt_rr_scheduler
    import sqrt_rr_scheduler_pkg::*;
#(
    parameter int  NUM_REQ     = 2,
    parameter int  TIMEOUT_CYC = 64,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*SIG_W-1:0] req_s_i,
    input  logic [NUM_REQ-1:0]       req_exp_odd_i,
    input  logic [NUM_REQ-1:0]       req_inv_i,
    input  logic [NUM_REQ-1:0]       req_special_i,
    output logic                     sqrt_do_o,
    output logic [SIG_W-1:0]         sqrt_s_o,
    output logic                     sqrt_exp_odd_o,
    output logic                     sqrt_inv_o,
    output logic                     sqrt_special_o,
    input  logic                     sqrt_valid_i,
    input  logic [SIG_W-1:0]         sqrt_res_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [SIG_W-1:0]         resp_res_o,
    output logic [ID_W-1:0]          resp_id_o,
    output logic                     resp_inv_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    sqrtSchedState_t  state_q, state_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [ID_W-1:0]  id_q, id_d;
    sqrt_req_t        op_q, op_d;
    logic [SIG_W-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i  (req_valid_i),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx),
        .any_o  (gnt_any)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        op_d    = op_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d    = ISSUE;
                    last_d     = gnt_idx;
                    id_d       = gnt_idx;
                    op_d.s       = req_s_i[int'(gnt_idx)*SIG_W +: SIG_W];
                    op_d.exp_odd = req_exp_odd_i[gnt_idx];
                    op_d.inv     = req_inv_i[gnt_idx];
                    op_d.special = req_special_i[gnt_idx];
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (sqrt_valid_i) begin
                    res_d   = sqrt_res_i;
                    state_d = RESP;
                end else if (cnt_q == CNT_MAX) begin
                    // The unit may still answer late, so keep waiting rather than abort.
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (sqrt_valid_i && state_q != WAIT) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            op_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            op_q    <= op_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // A grant presented during reset must not be accepted by the requester.
    assign req_ready_o    = (state_q == IDLE && !rst) ? gnt : '0;
    assign sqrt_do_o      = (state_q == ISSUE);
    assign sqrt_s_o       = op_q.s;
    assign sqrt_exp_odd_o = op_q.exp_odd;
    assign sqrt_inv_o     = op_q.inv;
    assign sqrt_special_o = op_q.special;
    assign resp_valid_o   = (state_q == RESP);
    assign resp_res_o     = res_q;
    assign resp_id_o      = id_q;
    assign resp_inv_o     = op_q.inv;
    assign busy_o         = (state_q != IDLE);
    assign err_o          = err_q;

endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
// Self-checking bench for sqrt_rr_scheduler with a stub square-root unit.
module tb_sqrt_rr_scheduler;

    localparam int N  = 2;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid_i;
    logic [N-1:0]   req_ready_o;
    logic [N*8-1:0] req_s_i;
    logic [N-1:0]   req_exp_odd_i, req_inv_i, req_special_i;
    logic           sqrt_do_o, sqrt_exp_odd_o, sqrt_inv_o, sqrt_special_o;
    logic [7:0]     sqrt_s_o;
    logic           sqrt_valid_i;
    logic [7:0]     sqrt_res_i;
    logic           resp_valid_o, resp_ready_i, resp_inv_o, busy_o, err_o;
    logic [7:0]     resp_res_o;
    logic [0:0]     resp_id_o;

    always #5 clk = ~clk;

    sqrt_rr_scheduler #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_s_i(req_s_i),
        .req_exp_odd_i(req_exp_odd_i), .req_inv_i(req_inv_i), .req_special_i(req_special_i),
        .sqrt_do_o(sqrt_do_o), .sqrt_s_o(sqrt_s_o), .sqrt_exp_odd_o(sqrt_exp_odd_o),
        .sqrt_inv_o(sqrt_inv_o), .sqrt_special_o(sqrt_special_o),
        .sqrt_valid_i(sqrt_valid_i), .sqrt_res_i(sqrt_res_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_res_o(resp_res_o),
        .resp_id_o(resp_id_o), .resp_inv_o(resp_inv_o), .busy_o(busy_o), .err_o(err_o)
    );

    // Stub unit: answers stub_lat cycles after do (1 cycle for specials) with s ^ 8'hFF (0 for specials).
    int         stub_lat = 5;
    bit         stub_mute = 0;
    logic       spur_valid = 1'b0;
    int         stub_cnt;
    logic       stub_valid;
    logic [7:0] stub_res;

    always @(posedge clk) begin
        if (rst) begin
            stub_cnt <= 0; stub_valid <= 1'b0; stub_res <= 8'h00;
        end else if (sqrt_do_o && !stub_mute) begin
            stub_res <= sqrt_special_o ? 8'h00 : (sqrt_s_o ^ 8'hFF);
            if (sqrt_special_o || stub_lat <= 1) begin
                stub_valid <= 1'b1; stub_cnt <= 0;
            end else begin
                stub_valid <= 1'b0; stub_cnt <= stub_lat - 1;
            end
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1; stub_valid <= (stub_cnt == 1);
        end else begin
            stub_valid <= 1'b0;
        end
    end

    assign sqrt_valid_i = stub_valid | spur_valid;
    assign sqrt_res_i   = stub_res;

    int errors = 0;
    int checks = 0;
    int model_last;
    logic [7:0] m_s[N];
    logic       m_odd[N], m_inv[N], m_spec[N];

    typedef struct {
        int gidx; int do_at; int do_cnt; int rv_at; int id;
        logic [7:0] op_s; logic op_odd; logic op_spec; logic [7:0] res; logic inv;
        bit rdy_extra; bit unstable; bit stall_rdy; bit stall_do;
    } op_obs_t;

    function automatic int model_grant(input logic [N-1:0] mask, input int last);
        int c;
        for (int i = 1; i <= N; i++) begin
            c = (last + i) % N;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_res(input int k);
        return m_spec[k] ? 8'h00 : (m_s[k] ^ 8'hFF);
    endfunction

    function automatic int model_lat(input int k);
        return (m_spec[k] ? 1 : stub_lat) + 2;
    endfunction

    task automatic set_req(input int k, input logic [7:0] s, input logic odd, input logic inv, input logic spec);
        m_s[k] = s; m_odd[k] = odd; m_inv[k] = inv; m_spec[k] = spec;
        req_s_i[k*8 +: 8] = s;
        req_exp_odd_i[k] = odd; req_inv_i[k] = inv; req_special_i[k] = spec;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid_i = '0; resp_ready_i = 1'b0; spur_valid = 1'b0; stub_mute = 0;
        req_s_i = '0; req_exp_odd_i = '0; req_inv_i = '0; req_special_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = N - 1;
    endtask

    // Runs one op starting at a negedge with requests already driven; observes only.
    task automatic run_op(input int stall, input bit hold, output op_obs_t o);
        int cyc;
        o.gidx = -1; o.do_at = -1; o.do_cnt = 0; o.rv_at = -1; o.id = -1;
        o.op_s = 8'h00; o.op_odd = 1'b0; o.op_spec = 1'b0; o.res = 8'h00; o.inv = 1'b0;
        o.rdy_extra = 0; o.unstable = 0; o.stall_rdy = 0; o.stall_do = 0;
        #1;
        for (int k = 0; k < N; k++)
            if (req_ready_o == N'(1 << k)) o.gidx = k;
        if (o.gidx < 0) return;
        cyc = 0;
        while (!resp_valid_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && !hold) req_valid_i[o.gidx] = 1'b0;
            #1;
            if (req_ready_o != '0) o.rdy_extra = 1;
            if (sqrt_do_o) begin
                o.do_cnt++;
                if (o.do_at < 0) o.do_at = cyc;
                o.op_s = sqrt_s_o; o.op_odd = sqrt_exp_odd_o; o.op_spec = sqrt_special_o;
            end
        end
        if (!resp_valid_o) return;
        o.rv_at = cyc; o.res = resp_res_o; o.id = int'(resp_id_o); o.inv = resp_inv_o;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk); #1;
            if (!resp_valid_o || resp_res_o !== o.res || int'(resp_id_o) != o.id || resp_inv_o !== o.inv)
                o.unstable = 1;
            if (req_ready_o != '0) o.stall_rdy = 1;
            if (sqrt_do_o) o.stall_do = 1;
        end
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({req_ready_o, sqrt_do_o, sqrt_s_o, sqrt_exp_odd_o, sqrt_inv_o, sqrt_special_o,
             resp_valid_o, resp_res_o, resp_id_o, resp_inv_o, busy_o, err_o} !== '0) begin
            errors++; $display("FAIL reset_outputs: busy=%b err=%b rv=%b do=%b res=%h", busy_o, err_o, resp_valid_o, sqrt_do_o, resp_res_o);
        end
        req_valid_i = 2'b11;
        #1;
        checks++;
        if (req_ready_o !== 2'b01) begin
            errors++; $display("FAIL reset_first_winner: got %b want 01", req_ready_o);
        end
    endtask

    task automatic test_single();
        op_obs_t o;
        logic odd, inv;
        int exp_g;
        do_reset();
        odd = 1'($urandom); inv = 1'($urandom);
        stub_lat = 5;
        set_req(0, 8'h80, odd, inv, 1'b0);
        req_valid_i = 2'b01;
        exp_g = model_grant(req_valid_i, model_last);
        run_op(0, 0, o);
        model_last = exp_g;
        checks++; if (o.gidx != exp_g) begin errors++; $display("FAIL single_grant: got %0d want %0d", o.gidx, exp_g); end
        checks++; if (o.do_at != 1 || o.do_cnt != 1) begin errors++; $display("FAIL single_do: at %0d count %0d want at 1 count 1", o.do_at, o.do_cnt); end
        checks++; if (o.op_s !== 8'h80 || o.op_odd !== odd) begin errors++; $display("FAIL single_operands: s=%h odd=%b want 80 %b", o.op_s, o.op_odd, odd); end
        checks++; if (o.rv_at != 7) begin errors++; $display("FAIL single_latency: got %0d want 7", o.rv_at); end
        checks++; if (o.res !== 8'h7F || o.id != 0 || o.inv !== inv) begin errors++; $display("FAIL single_resp: res=%h id=%0d inv=%b want 7f 0 %b", o.res, o.id, o.inv, inv); end
        checks++; if (o.rdy_extra) begin errors++; $display("FAIL single_ready_busy: got 1 want 0"); end
    endtask

    task automatic test_round_robin();
        op_obs_t o;
        int exp_g;
        logic [7:0] exp_r;
        do_reset();
        stub_lat = 3;
        for (int k = 0; k < N; k++) set_req(k, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        req_valid_i = 2'b11;
        for (int n = 0; n < 4; n++) begin
            exp_g = model_grant(req_valid_i, model_last);
            exp_r = model_res(exp_g);
            run_op(0, 1, o);
            model_last = exp_g;
            checks++; if (o.gidx != exp_g || o.gidx != n % 2) begin errors++; $display("FAIL rr_grant%0d: got %0d want %0d", n, o.gidx, exp_g); end
            checks++; if (o.id != exp_g || o.res !== exp_r) begin errors++; $display("FAIL rr_resp%0d: id=%0d res=%h want %0d %h", n, o.id, o.res, exp_g, exp_r); end
            if (o.gidx >= 0) set_req(o.gidx, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    task automatic test_back_to_back_stall();
        op_obs_t o;
        do_reset();
        stub_lat = $urandom_range(1, 8);
        for (int k = 0; k < N; k++) set_req(k, 8'($urandom), 1'b0, 1'($urandom), 1'b0);
        req_valid_i = 2'b11;
        run_op(10, 1, o);
        model_last = 0;
        checks++; if (o.gidx != 0 || o.res !== model_res(0)) begin errors++; $display("FAIL stall_resp: g=%0d res=%h want 0 %h", o.gidx, o.res, model_res(0)); end
        checks++; if (o.unstable) begin errors++; $display("FAIL stall_stable: got unstable want stable"); end
        checks++; if (o.stall_rdy || o.stall_do) begin errors++; $display("FAIL stall_quiet: rdy=%0d do=%0d want 0 0", o.stall_rdy, o.stall_do); end
        #1;
        checks++; if (req_ready_o !== 2'b10) begin errors++; $display("FAIL stall_next_grant: got %b want 10", req_ready_o); end
    endtask

    task automatic test_special();
        op_obs_t o;
        do_reset();
        stub_lat = 5;
        set_req(1, 8'hC3, 1'b1, 1'b1, 1'b1);
        req_valid_i = 2'b10;
        run_op(0, 0, o);
        checks++; if (o.op_spec !== 1'b1 || o.op_s !== 8'hC3) begin errors++; $display("FAIL special_operands: spec=%b s=%h want 1 c3", o.op_spec, o.op_s); end
        checks++; if (o.res !== 8'h00 || o.id != 1 || o.rv_at != 3) begin errors++; $display("FAIL special_resp: res=%h id=%0d at=%0d want 00 1 3", o.res, o.id, o.rv_at); end
    endtask

    task automatic test_random();
        op_obs_t o;
        int exp_g;
        do_reset();
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < N; k++)
                set_req(k, 8'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
            stub_lat = $urandom_range(1, 6);
            req_valid_i = N'($urandom_range(1, 3));
            exp_g = model_grant(req_valid_i, model_last);
            run_op($urandom_range(0, 3), 0, o);
            checks++;
            if (o.gidx != exp_g || o.id != exp_g || o.res !== model_res(exp_g) || o.inv !== m_inv[exp_g] || o.rv_at != model_lat(exp_g)) begin
                errors++; $display("FAIL random%0d: g=%0d id=%0d res=%h inv=%b at=%0d want g=%0d res=%h inv=%b at=%0d",
                                   n, o.gidx, o.id, o.res, o.inv, o.rv_at, exp_g, model_res(exp_g), m_inv[exp_g], model_lat(exp_g));
            end
            model_last = exp_g;
            req_valid_i = '0;
        end
    endtask

    task automatic test_timeout();
        bit early;
        do_reset();
        stub_mute = 1;
        set_req(0, 8'h55, 1'b0, 1'b0, 1'b0);
        req_valid_i = 2'b01;
        @(negedge clk); req_valid_i = '0;   // ISSUE
        @(negedge clk);                     // first WAIT cycle
        early = 0;
        for (int k = 0; k < TO; k++) begin
            #1; if (err_o) early = 1;
            @(negedge clk);
        end
        #1;
        checks++; if (early) begin errors++; $display("FAIL timeout_early: err rose before %0d WAIT cycles", TO); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", err_o); end
        repeat (10) @(negedge clk);
        #1;
        checks++; if (err_o !== 1'b1 || busy_o !== 1'b1 || resp_valid_o !== 1'b0 || sqrt_do_o !== 1'b0) begin
            errors++; $display("FAIL timeout_hold: err=%b busy=%b rv=%b do=%b want 1 1 0 0", err_o, busy_o, resp_valid_o, sqrt_do_o);
        end
    endtask

    task automatic test_reset_mid_and_spurious();
        rst = 1'b1; req_valid_i = 2'b11;
        #1;
        checks++; if (req_ready_o !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", req_ready_o); end
        @(negedge clk);
        rst = 1'b0; req_valid_i = '0; stub_mute = 0;
        #1;
        checks++;
        if ({req_ready_o, sqrt_do_o, sqrt_s_o, sqrt_exp_odd_o, sqrt_inv_o, sqrt_special_o,
             resp_valid_o, resp_res_o, resp_id_o, resp_inv_o, busy_o, err_o} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: busy=%b err=%b rv=%b s=%h", busy_o, err_o, resp_valid_o, sqrt_s_o);
        end
        @(negedge clk); spur_valid = 1'b1;
        @(negedge clk); spur_valid = 1'b0;
        #1;
        checks++; if (err_o !== 1'b1 || resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL spurious: err=%b rv=%b busy=%b want 1 0 0", err_o, resp_valid_o, busy_o);
        end
        req_valid_i = 2'b11;
        #1;
        checks++; if (req_ready_o !== 2'b01) begin errors++; $display("FAIL rst_mid_winner: got %b want 01", req_ready_o); end
        req_valid_i = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back_stall();
        test_special();
        test_random();
        test_timeout();
        test_reset_mid_and_spurious();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
